// File: rtl/isw_pkg.sv
// Shared helpers for the ISW masked-AND blocks: share count, random-bit count
// and the row-major (i<j) pair index used to lay out rand_in and cross terms.
package isw_pkg;

  function automatic int n_shares(input int d);
    return d + 1;
  endfunction

  function automatic int n_rand(input int d);
    return (d * (d + 1)) / 2;
  endfunction

  // Row-major position of pair (i,j), i<j, among all share pairs of order d.
  function automatic int pair_idx(input int i, input int j, input int d);
    return i * (d + 1) - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/isw_mul_core.sv
// One ISW masked-AND copy of order D over W bit-sliced lanes, two register stages:
// stage 1 holds diagonal/cross products and the masks, stage 2 holds output shares.
module isw_mul_core
  import isw_pkg::*;
#(
  parameter int D = 1,
  parameter int W = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [n_shares(D)*W-1:0]     a_in,
  input  logic [n_shares(D)*W-1:0]     b_in,
  input  logic [n_rand(D)*W-1:0]       rand_in,
  output logic [n_shares(D)*W-1:0]     c_out
);

  localparam int N = n_shares(D);
  localparam int R = n_rand(D);

  logic [N*W-1:0] w_p_next;
  logic [R*W-1:0] w_t_next;
  logic [R*W-1:0] w_u_next;
  logic [N*W-1:0] w_c_next;

  logic [N*W-1:0] r_p;
  logic [R*W-1:0] r_t;
  logic [R*W-1:0] r_u;
  logic [R*W-1:0] r_r;
  logic [N*W-1:0] r_c;

  genvar gi, gj;

  for (gi = 0; gi < N; gi++) begin : g_share
    assign w_p_next[gi*W +: W] = a_in[gi*W +: W] & b_in[gi*W +: W];
    for (gj = gi + 1; gj < N; gj++) begin : g_pair
      localparam int K = pair_idx(gi, gj, D);
      assign w_t_next[K*W +: W] = (a_in[gi*W +: W] & b_in[gj*W +: W]) ^ rand_in[K*W +: W];
      assign w_u_next[K*W +: W] = a_in[gj*W +: W] & b_in[gi*W +: W];
    end
  end

  // Every operand below is a stage-1 register; t and u are only combined after registering.
  always_comb begin
    w_c_next = r_p;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j > i) begin
          w_c_next[i*W +: W] = w_c_next[i*W +: W] ^ r_r[pair_idx(i, j, D)*W +: W];
        end else if (j < i) begin
          w_c_next[i*W +: W] = w_c_next[i*W +: W]
                               ^ r_t[pair_idx(j, i, D)*W +: W]
                               ^ r_u[pair_idx(j, i, D)*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= '0;
      r_t <= '0;
      r_u <= '0;
      r_r <= '0;
      r_c <= '0;
    end else begin
      r_p <= w_p_next;
      r_t <= w_t_next;
      r_u <= w_u_next;
      r_r <= rand_in;
      r_c <= w_c_next;
    end
  end

  assign c_out = r_c;

endmodule

// File: rtl/isw_mul_dup_checked.sv
// Spatially duplicated ISW AND with share-wise comparison and sticky alarm.
// Define ISW_DUP_INFECT_EN to zero c_out on any cycle with a detected mismatch.
module isw_mul_dup_checked
  import isw_pkg::*;
#(
  parameter int D = 1,
  parameter int W = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [n_shares(D)*W-1:0]     a_in,
  input  logic [n_shares(D)*W-1:0]     b_in,
  input  logic [n_rand(D)*W-1:0]       rand_in,
  output logic                         out_valid,
  output logic [n_shares(D)*W-1:0]     c_out,
  output logic [n_shares(D)*W-1:0]     det_out,
  output logic                         fault_o,
  input  logic                         fault_clr
);

  localparam int N = n_shares(D);

  logic [N*W-1:0] w_a_buf;
  logic [N*W-1:0] w_c0;
  logic [N*W-1:0] w_c1;
  logic [N*W-1:0] w_det;
  logic           w_set;
  logic [1:0]     r_valid;
  logic           r_fault;

  genvar gi;

  // Copy 0 sees a_in through its own per-bit nets so the two copies stay disjoint.
  for (gi = 0; gi < N*W; gi++) begin : g_abuf
    assign w_a_buf[gi] = a_in[gi];
  end

  isw_mul_core #(.D(D), .W(W)) u_core0 (
    .clk     (clk),
    .reset   (reset),
    .a_in    (w_a_buf),
    .b_in    (b_in),
    .rand_in (rand_in),
    .c_out   (w_c0)
  );

  isw_mul_core #(.D(D), .W(W)) u_core1 (
    .clk     (clk),
    .reset   (reset),
    .a_in    (a_in),
    .b_in    (b_in),
    .rand_in (rand_in),
    .c_out   (w_c1)
  );

  assign w_det = ~(w_c0 ^ w_c1);
  assign w_set = r_valid[1] & ~(&w_det);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 2'b00;
      r_fault <= 1'b0;
    end else begin
      r_valid <= {r_valid[0], in_valid};
      if (w_set) begin
        r_fault <= 1'b1;
      end else if (fault_clr) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid[1];
  assign det_out   = w_det;
  assign fault_o   = r_fault;

`ifdef ISW_DUP_INFECT_EN
  assign c_out = w_set ? '0 : w_c0;
`else
  assign c_out = w_c0;
`endif

endmodule

// File: tb/tb_isw_mul_dup_checked.sv
// Bench: directed D=1/W=1 vectors and fault injection, plus a D=2/W=4 instance
// checked every cycle against a behavioural ISW model.
module tb_isw_mul_dup_checked;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

`ifdef ISW_DUP_INFECT_EN
  localparam logic [1:0] FLIP_C = 2'b00;
`else
  localparam logic [1:0] FLIP_C = 2'b11;
`endif

  // D=1, W=1 instance
  logic       va, clra, ova, fa;
  logic [1:0] aa, ba, ca, da;
  logic [0:0] ra;

  // D=2, W=4 instance
  logic        vb, clrb, ovb, fb;
  logic [11:0] ab, bb, rb, cb, db;

  isw_mul_dup_checked #(.D(1), .W(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .a_in(aa), .b_in(ba), .rand_in(ra),
    .out_valid(ova), .c_out(ca), .det_out(da), .fault_o(fa), .fault_clr(clra)
  );

  isw_mul_dup_checked #(.D(2), .W(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .a_in(ab), .b_in(bb), .rand_in(rb),
    .out_valid(ovb), .c_out(cb), .det_out(db), .fault_o(fb), .fault_clr(clrb)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ISW output shares for N=3 over 4 lanes, straight from the share equations.
  function automatic logic [11:0] isw_ref(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] r);
    logic [11:0] c;
    logic        rr [0:2][0:2];
    int          k;
    c = '0;
    for (int l = 0; l < 4; l++) begin
      k = 0;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) rr[i][j] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = i + 1; j < 3; j++) begin
          rr[i][j] = r[k*4+l];
          k++;
        end
      end
      for (int i = 0; i < 3; i++) begin
        logic s;
        s = a[i*4+l] & b[i*4+l];
        for (int j = 0; j < 3; j++) begin
          if (j > i) s = s ^ rr[i][j];
          else if (j < i) s = s ^ rr[j][i] ^ (a[j*4+l] & b[i*4+l]) ^ (a[i*4+l] & b[j*4+l]);
        end
        c[i*4+l] = s;
      end
    end
    return c;
  endfunction

  function automatic logic [3:0] fold(input logic [11:0] x);
    return x[3:0] ^ x[7:4] ^ x[11:8];
  endfunction

  typedef struct packed {
    logic        v;
    logic [11:0] c;
    logic [3:0]  prod;
  } ent_t;

  ent_t pipe [0:1];

  initial begin
    pipe[0] = '0;
    pipe[1] = '0;
  end

  // Two-cycle delay line of expected results; reset discards everything in flight.
  always @(posedge clk) begin
    if (reset) begin
      pipe[0] = '0;
      pipe[1] = '0;
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = {vb, isw_ref(ab, bb, rb), fold(ab) & fold(bb)};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("b_valid", ovb, pipe[1].v);
      chk("b_c", cb, pipe[1].c);
      chk("b_det", db, 12'hfff);
      chk("b_fault", fb, 1'b0);
      if (ovb && pipe[1].v) chk("b_unmask", fold(cb), pipe[1].prod);
    end
  end

  initial begin
    int lat;
    int ops;
    va = 0; clra = 0; aa = 0; ba = 0; ra = 0;
    vb = 0; clrb = 0; ab = 0; bb = 0; rb = 0;
    reset = 1'b1;
    tick();
    tick();
    cmp_en = 1'b1;
    chk("a_rst_valid", ova, 1'b0);
    chk("a_rst_c", ca, 2'b00);
    chk("a_rst_det", da, 2'b11);
    chk("a_rst_fault", fa, 1'b0);
    reset = 1'b0;

    chk("model_pin0", isw_ref(12'h011, 12'h101, 12'h000), 12'h011);
    chk("model_pin1", isw_ref(12'h011, 12'h101, 12'h001), 12'h000);

    // a=(1,0), b=(1,1), r=0 -> c=(1,1)
    aa = 2'b01; ba = 2'b11; ra = 1'b0; va = 1'b1;
    tick();
    va = 1'b0;
    tick();
    chk("a_vec0_valid", ova, 1'b1);
    chk("a_vec0_c", ca, 2'b11);
    chk("a_vec0_det", da, 2'b11);
    chk("a_vec0_fault", fa, 1'b0);

    ra = 1'b1; va = 1'b1;
    tick();
    va = 1'b0;
    tick();
    chk("a_vec1_valid", ova, 1'b1);
    chk("a_vec1_c", ca, 2'b00);

    // Flip copy-1 share 0 while output is valid
    ra = 1'b0; va = 1'b1;
    tick();
    va = 1'b0;
    tick();
    force dut_a.w_c1 = 2'b10;
    #1;
    chk("a_flip_det", da, 2'b10);
    chk("a_flip_c", ca, FLIP_C);
    chk("a_flip_fault_pre", fa, 1'b0);
    tick();
    release dut_a.w_c1;
    chk("a_flip_fault_set", fa, 1'b1);
    tick();
    tick();
    chk("a_fault_sticky", fa, 1'b1);
    clra = 1'b1;
    tick();
    clra = 1'b0;
    chk("a_fault_clr", fa, 1'b0);

    // Flip coincident with clear: set wins
    va = 1'b1;
    tick();
    va = 1'b0;
    tick();
    force dut_a.w_c1 = 2'b10;
    clra = 1'b1;
    #1;
    chk("a_coinc_det", da, 2'b10);
    tick();
    release dut_a.w_c1;
    clra = 1'b0;
    chk("a_coinc_fault", fa, 1'b1);
    clra = 1'b1;
    tick();
    clra = 1'b0;
    chk("a_coinc_clr", fa, 1'b0);

    // Flip while out_valid=0 leaves the alarm alone
    tick();
    chk("a_idle_valid", ova, 1'b0);
    force dut_a.w_c1 = 2'b10;
    #1;
    chk("a_idle_det", da, 2'b10);
    chk("a_idle_c", ca, 2'b11);
    tick();
    tick();
    release dut_a.w_c1;
    chk("a_idle_fault", fa, 1'b0);

    // Hand vector on the D=2, W=4 instance (lane 0 only)
    ab = 12'h011; bb = 12'h101; rb = 12'h000; vb = 1'b1;
    tick();
    vb = 1'b0;
    tick();
    chk("b_vec_valid", ovb, 1'b1);
    chk("b_vec_c", cb, 12'h011);

    // Back-to-back ops with reset landing on the second one
    ab = 12'h5a3; bb = 12'hc3f; rb = 12'h9e1; vb = 1'b1;
    tick();
    ab = 12'h0ff; reset = 1'b1;
    tick();
    ab = 12'h777;
    tick();
    chk("b_rst_valid", ovb, 1'b0);
    chk("b_rst_c", cb, 12'h000);
    chk("b_rst_det", db, 12'hfff);
    reset = 1'b0; vb = 1'b0;
    tick();
    chk("b_post_rst_valid", ovb, 1'b0);
    vb = 1'b1;
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      vb = 1'b0;
      lat++;
      if (ovb) break;
    end
    chk("b_post_rst_latency", lat, 2);

    // Random operand stream with bubbles
    ops = 0;
    while (ops < 1000) begin
      vb = ($urandom_range(0, 3) != 0);
      ab = 12'($urandom);
      bb = 12'($urandom);
      rb = 12'($urandom);
      if (vb) ops++;
      tick();
    end
    vb = 1'b0;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
